// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: direction encodings
// and the wrap/saturate mode selectors.
package counter_pkg;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/udc_tff_bit.sv
// One counter bit: a T flip-flop with asynchronous active-low reset and a
// synchronous override (load) path that takes priority over the toggle.
module udc_tff_bit
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_tog,
    input  logic i_ld,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    // Bit state: override wins over toggle, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (i_ld) begin
            r_q <= i_d;
        end else if (i_tog) begin
            r_q <= ~r_q;
        end
    end

    assign o_q = r_q;

endmodule : udc_tff_bit

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter built from a T flip-flop chain.
// For a power-of-two modulus the toggle chain alone wraps naturally; for
// other moduli (and in saturate mode) an override path reloads the limit
// value. Optional sticky overflow/underflow flags are compiled in when the
// macro UDC_STATUS_EN is defined.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDC_STATUS_EN
    input  logic             clr_status,
    output logic             ovf,
    output logic             unf,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam longint unsigned FULL_RANGE = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 64'd1);
    localparam bit IS_POW2 = (MODULUS == FULL_RANGE);
    localparam bit IS_SAT  = (SATURATE == MODE_SAT);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("sync_updown_counter: WIDTH must be in 1..32");
        end
        if (MODULUS < 2 || MODULUS > FULL_RANGE) begin : g_bad_modulus
            $error("sync_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_tog;
    logic [WIDTH-1:0] w_ovr_val;
    logic             w_ovr;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_limit;
    logic             w_load_clamp;
    logic             r_wrap;

    assign w_at_max     = (w_q == MAX_VAL);
    assign w_at_zero    = (w_q == '0);
    assign w_at_limit   = (up_dn == UP) ? w_at_max : w_at_zero;
    assign w_load_clamp = (load_val > MAX_VAL);

    // Terminal count ignores load so a cascaded stage sees a clean enable.
    assign tc = en & w_at_limit;

    // Override fires on load, or at a limit whenever the plain toggle chain
    // would produce the wrong value (non-power-of-two wrap, or saturation).
    assign w_ovr = load | (tc & (IS_SAT | ~IS_POW2));

    // Value forced into the bit cells when the override path is active.
    always_comb begin
        w_ovr_val = w_q;
        if (load) begin
            w_ovr_val = w_load_clamp ? MAX_VAL : load_val;
        end else if (IS_SAT) begin
            w_ovr_val = w_q;
        end else if (up_dn == UP) begin
            w_ovr_val = '0;
        end else begin
            w_ovr_val = MAX_VAL;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Bit gi toggles when every lower bit is at its carry/borrow value.
            if (gi == 0) begin : g_lsb
                assign w_tog[gi] = en;
            end else begin : g_upper
                assign w_tog[gi] = en & ((up_dn == UP) ? (&w_q[gi-1:0])
                                                       : (&(~w_q[gi-1:0])));
            end

            udc_tff_bit u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .i_tog (w_tog[gi]),
                .i_ld  (w_ovr),
                .i_d   (w_ovr_val[gi]),
                .o_q   (w_q[gi])
            );
        end
    endgenerate

    // Wrap pulse: one cycle after an enabled limit crossing in wrap mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= ~load & tc & ~IS_SAT;
        end
    end

`ifdef UDC_STATUS_EN
    logic r_ovf;
    logic r_unf;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = ~load & en & (up_dn == UP)   & w_at_max;
    assign w_unf_set = ~load & en & (up_dn == DOWN) & w_at_zero;

    // Sticky status flags; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~clr_status);
            r_unf <= w_unf_set | (r_unf & ~clr_status);
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`endif

    assign q    = w_q;
    assign wrap = r_wrap;

endmodule : sync_updown_counter

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench for sync_updown_counter: a wrapping MOD-10 counter, a
// saturating MOD-10 counter and a two-stage MOD-16 cascade.
module tb_sync_updown_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: MOD-10 wrap
    logic       en0, up0, ld0, clr0;
    logic [3:0] lv0, q0;
    logic       tc0, w0, ovf0, unf0;
    // DUT 1: MOD-10 saturate
    logic       en1, up1, ld1, clr1;
    logic [3:0] lv1, q1;
    logic       tc1, w1, ovf1, unf1;
    // DUT 2: cascade of two MOD-16 stages
    logic       cen, cup;
    logic [3:0] cq0, cq1;
    logic       ctc0, ctc1, cw0, cw1;
    logic       covf0, cunf0, covf1, cunf1;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en0), .up_dn(up0), .load(ld0), .load_val(lv0),
`ifdef UDC_STATUS_EN
        .clr_status(clr0), .ovf(ovf0), .unf(unf0),
`endif
        .q(q0), .tc(tc0), .wrap(w0)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en1), .up_dn(up1), .load(ld1), .load_val(lv1),
`ifdef UDC_STATUS_EN
        .clr_status(clr1), .ovf(ovf1), .unf(unf1),
`endif
        .q(q1), .tc(tc1), .wrap(w1)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_c0 (
        .clk(clk), .rst_n(rst_n), .en(cen), .up_dn(cup), .load(1'b0), .load_val(4'h0),
`ifdef UDC_STATUS_EN
        .clr_status(1'b0), .ovf(covf0), .unf(cunf0),
`endif
        .q(cq0), .tc(ctc0), .wrap(cw0)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .en(ctc0), .up_dn(cup), .load(1'b0), .load_val(4'h0),
`ifdef UDC_STATUS_EN
        .clr_status(1'b0), .ovf(covf1), .unf(cunf1),
`endif
        .q(cq1), .tc(ctc1), .wrap(cw1)
    );

    typedef struct {
        int         id;
        int         dut;
        logic [7:0] eq;
        logic       etc;
        logic       ew;
        logic       eo;
        logic       eu;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vid      = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic idle_all();
        en0 = 0; up0 = 1; ld0 = 0; clr0 = 0; lv0 = 0;
        en1 = 0; up1 = 1; ld1 = 0; clr1 = 0; lv1 = 0;
        cen = 0; cup = 1;
    endtask

    // Drive one cycle of stimulus on a DUT and queue the post-edge response.
    task automatic stim(input int dut, input bit en, input bit up, input bit ld,
                        input bit clr, input logic [7:0] lv, input logic [7:0] eq,
                        input bit etc, input bit ew, input bit eo, input bit eu);
        exp_t e;
        @(negedge clk);
        idle_all();
        case (dut)
            0: begin en0 = en; up0 = up; ld0 = ld; clr0 = clr; lv0 = lv[3:0]; end
            1: begin en1 = en; up1 = up; ld1 = ld; clr1 = clr; lv1 = lv[3:0]; end
            default: begin cen = en; cup = up; end
        endcase
        e.id = vid; e.dut = dut; e.eq = eq; e.etc = etc; e.ew = ew; e.eo = eo; e.eu = eu;
        sb.push_back(e);
        vid++;
    endtask

    task automatic s0(input bit en, input bit up, input bit ld, input logic [7:0] lv,
                      input logic [7:0] eq, input bit etc, input bit ew);
        stim(0, en, up, ld, 1'b0, lv, eq, etc, ew, 1'b0, 1'b0);
    endtask

    // Monitor: every clock the counters present a new state; compare it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0: begin
                        chk("q_wrapdut", e.id, {28'd0, q0}, {24'd0, e.eq});
                        chk("tc_wrapdut", e.id, {31'd0, tc0}, {31'd0, e.etc});
                        chk("wrap_wrapdut", e.id, {31'd0, w0}, {31'd0, e.ew});
                    end
                    1: begin
                        chk("q_satdut", e.id, {28'd0, q1}, {24'd0, e.eq});
                        chk("tc_satdut", e.id, {31'd0, tc1}, {31'd0, e.etc});
                        chk("wrap_satdut", e.id, {31'd0, w1}, {31'd0, e.ew});
`ifdef UDC_STATUS_EN
                        chk("ovf_satdut", e.id, {31'd0, ovf1}, {31'd0, e.eo});
                        chk("unf_satdut", e.id, {31'd0, unf1}, {31'd0, e.eu});
`endif
                    end
                    default: begin
                        chk("q_cascade", e.id, {24'd0, cq1, cq0}, {24'd0, e.eq});
                        chk("tc_cascade", e.id, {31'd0, ctc1}, {31'd0, e.etc});
                        chk("wrap_cascade", e.id, {31'd0, cw1}, {31'd0, e.ew});
                    end
                endcase
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #2;
        chk("drain_pending", vid, sb.size(), 0);
    endtask

    initial begin
        idle_all();
        // Reset state, with tc observed in the down direction while q=0.
        en0 = 1; up0 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 0, {28'd0, q0}, 0);
        chk("reset_wrap", 0, {31'd0, w0}, 0);
        chk("reset_tc_down_en", 0, {31'd0, tc0}, 1);
        chk("reset_q_cascade", 0, {24'd0, cq1, cq0}, 0);
        @(negedge clk);
        idle_all();
        rst_n = 1;

        // Count up through the MOD-10 wrap.
        for (int i = 1; i <= 12; i++)
            s0(1, 1, 0, 0, 8'(i % 10), (i % 10) == 9, i == 10);

        // Load zero then count down through the wrap.
        s0(1, 0, 1, 8'd0, 8'd0, 1, 0);
        s0(1, 0, 0, 8'd0, 8'd9, 0, 1);
        s0(1, 0, 0, 8'd0, 8'd8, 0, 0);
        s0(1, 0, 0, 8'd0, 8'd7, 0, 0);
        s0(1, 0, 0, 8'd0, 8'd6, 0, 0);

        // Load: priority over enable, clamp, and no wrap when loading at limit.
        s0(1, 1, 1, 8'd6,  8'd6, 0, 0);
        s0(1, 1, 1, 8'd13, 8'd9, 1, 0);
        s0(1, 1, 1, 8'd3,  8'd3, 0, 0);
        s0(0, 1, 0, 8'd0,  8'd3, 0, 0);
        s0(1, 0, 0, 8'd0,  8'd2, 0, 0);
        s0(1, 1, 0, 8'd0,  8'd3, 0, 0);
        s0(0, 0, 1, 8'd1,  8'd1, 0, 0);
        s0(1, 0, 0, 8'd0,  8'd0, 1, 0);
        s0(0, 0, 0, 8'd0,  8'd0, 0, 0);
        s0(1, 0, 0, 8'd0,  8'd9, 0, 1);
        s0(0, 0, 0, 8'd0,  8'd9, 0, 0);

        // Saturate mode with sticky status.
        stim(1, 0, 1, 1, 0, 8'd7, 8'd7, 0, 0, 0, 0);
        stim(1, 1, 1, 0, 0, 8'd0, 8'd8, 0, 0, 0, 0);
        stim(1, 1, 1, 0, 0, 8'd0, 8'd9, 1, 0, 0, 0);
        stim(1, 1, 1, 0, 0, 8'd0, 8'd9, 1, 0, 1, 0);
        stim(1, 1, 1, 0, 0, 8'd0, 8'd9, 1, 0, 1, 0);
        stim(1, 1, 1, 0, 0, 8'd0, 8'd9, 1, 0, 1, 0);
        stim(1, 0, 1, 0, 1, 8'd0, 8'd9, 0, 0, 0, 0);
        stim(1, 1, 1, 0, 1, 8'd0, 8'd9, 1, 0, 1, 0);
        stim(1, 0, 1, 0, 1, 8'd0, 8'd9, 0, 0, 0, 0);
        stim(1, 0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 0);
        stim(1, 1, 0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 1);
        stim(1, 1, 0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 1);

        // Cascade: full 8-bit roll-over, then on to 0x5A.
        for (int i = 1; i <= 256 + 8'h5A; i++)
            stim(2, 1, 1, 0, 0, 8'd0, i[7:0], (i % 256) == 255, i == 256, 0, 0);
        @(negedge clk);
        idle_all();
        drain();

        // Asynchronous reset away from any clock edge.
        rst_n = 0;
        #1;
        chk("async_rst_cascade_q", vid, {24'd0, cq1, cq0}, 0);
        chk("async_rst_cascade_wrap", vid, {31'd0, cw1}, 0);
        chk("async_rst_wrapdut_q", vid, {28'd0, q0}, 0);
        @(negedge clk);
        rst_n = 1;
        stim(2, 1, 1, 0, 0, 8'd0, 8'd1, 0, 0, 0, 0);
        s0(1, 1, 0, 8'd0, 8'd1, 0, 0);
        @(negedge clk);
        idle_all();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_updown_counter
